// File: rtl/sys_bus_arbiter.sv
// Two-master data-side bus arbiter with fixed memory-map decode.
// Master 0 (CPU M-stage) has priority; master 1 (loader/debug) is
// guaranteed a grant after MAX_WAIT consecutive denied cycles.
// Responses (rvalid/err/rdata) arrive one cycle after the grant.
module sys_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_be,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_be,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic        o_m0_err,
    output logic [31:0] o_m0_rdata,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic        o_m1_err,
    output logic [31:0] o_m1_rdata,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [3:0]  o_s_be,
    output logic        o_dm_we,
    output logic        o_tc0_we,
    output logic        o_tc1_we,
    output logic        o_ig_we,
    input  logic [31:0] i_dm_rdata,
    input  logic [31:0] i_tc0_rdata,
    input  logic [31:0] i_tc1_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]  r_wait_cnt;
    logic        r_valid;
    logic        r_owner;
    logic        r_read;
    logic        r_err;
    logic        r_dm_sel;
    logic [31:0] r_data;

    logic        w_m0_gnt;
    logic        w_m1_gnt;
    logic        w_any_gnt;
    logic        w_we;
    logic        w_hit_dm;
    logic        w_hit_tc0;
    logic        w_hit_tc1;
    logic        w_hit_ig;
    logic        w_hit_tc;
    logic        w_err;
    logic        w_resp;
    logic [31:0] w_rdata;

    // Arbitration: m1 wins when m0 is idle or m1 has waited MAX_WAIT cycles.
    // Grants are held low during reset so no access is issued.
    always_comb begin
        w_m1_gnt  = ~i_reset & i_m1_req & (~i_m0_req | (r_wait_cnt == LP_MAX_WAIT));
        w_m0_gnt  = ~i_reset & i_m0_req & ~w_m1_gnt;
        w_any_gnt = w_m0_gnt | w_m1_gnt;
    end

    // Slave bus mux: granted master's signals, zero when idle.
    always_comb begin
        o_s_addr  = 32'h0;
        o_s_wdata = 32'h0;
        o_s_be    = 4'h0;
        w_we      = 1'b0;
        if (w_m0_gnt) begin
            o_s_addr  = i_m0_addr;
            o_s_wdata = i_m0_wdata;
            o_s_be    = i_m0_be;
            w_we      = i_m0_we;
        end else if (w_m1_gnt) begin
            o_s_addr  = i_m1_addr;
            o_s_wdata = i_m1_wdata;
            o_s_be    = i_m1_be;
            w_we      = i_m1_we;
        end
    end

    // Address decode and access-legality check on the granted access.
    always_comb begin
        w_hit_dm  = (o_s_addr <= 32'h0000_2FFF);
        w_hit_tc0 = (o_s_addr >= 32'h0000_7F00) && (o_s_addr <= 32'h0000_7F0B);
        w_hit_tc1 = (o_s_addr >= 32'h0000_7F10) && (o_s_addr <= 32'h0000_7F1B);
        w_hit_ig  = (o_s_addr >= 32'h0000_7F20) && (o_s_addr <= 32'h0000_7F23);
        w_hit_tc  = w_hit_tc0 | w_hit_tc1;
        // COUNT sits at timer word offset 0x8 and is read-only.
        w_err = ~(w_hit_dm | w_hit_tc | w_hit_ig)
              | (w_hit_tc & (o_s_be != 4'b1111))
              | (w_hit_tc & w_we & (o_s_addr[3:2] == 2'b10))
              | (o_s_be == 4'b0000);
    end

    // Per-slave write strobes, suppressed on error.
    always_comb begin
        o_dm_we  = w_any_gnt & w_we & w_hit_dm  & ~w_err;
        o_tc0_we = w_any_gnt & w_we & w_hit_tc0 & ~w_err;
        o_tc1_we = w_any_gnt & w_we & w_hit_tc1 & ~w_err;
        o_ig_we  = w_any_gnt & w_we & w_hit_ig  & ~w_err;
    end

    // Bounded-wait counter for master 1, saturating at MAX_WAIT.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wait_cnt <= 4'h0;
        end else if (i_m1_req && !w_m1_gnt) begin
            if (r_wait_cnt != LP_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'h1;
            end
        end else begin
            r_wait_cnt <= 4'h0;
        end
    end

    // Response capture at grant; timer read data is sampled here since it
    // is only valid while s_addr points at the timer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid  <= 1'b0;
            r_owner  <= 1'b0;
            r_read   <= 1'b0;
            r_err    <= 1'b0;
            r_dm_sel <= 1'b0;
            r_data   <= 32'h0;
        end else begin
            r_valid  <= w_any_gnt;
            r_owner  <= w_m1_gnt;
            r_read   <= w_any_gnt & ~w_we;
            r_err    <= w_any_gnt & w_err;
            r_dm_sel <= w_any_gnt & ~w_we & w_hit_dm & ~w_err;
            if (w_any_gnt && !w_we && !w_err && w_hit_tc0) begin
                r_data <= i_tc0_rdata;
            end else if (w_any_gnt && !w_we && !w_err && w_hit_tc1) begin
                r_data <= i_tc1_rdata;
            end else begin
                r_data <= 32'h0;
            end
        end
    end

    // Response mux, routed only to the owning master; a response pending
    // across reset is dropped.
    always_comb begin
        w_resp  = r_valid & ~i_reset;
        w_rdata = 32'h0;
        if (r_read && !r_err) begin
            w_rdata = r_dm_sel ? i_dm_rdata : r_data;
        end
        o_m0_rvalid = w_resp & ~r_owner;
        o_m1_rvalid = w_resp & r_owner;
        o_m0_err    = o_m0_rvalid & r_err;
        o_m1_err    = o_m1_rvalid & r_err;
        o_m0_rdata  = o_m0_rvalid ? w_rdata : 32'h0;
        o_m1_rdata  = o_m1_rvalid ? w_rdata : 32'h0;
        o_m0_gnt    = w_m0_gnt;
        o_m1_gnt    = w_m1_gnt;
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: decode, error cases, arbitration
// fairness, pipelined responses and reset discard.
module tb_sys_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        dm_we, tc0_we, tc1_we, ig_we;
    logic [31:0] dm_rdata, tc0_rdata, tc1_rdata;

    int errors = 0;
    int checks = 0;

    bit exp_m1 [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    sys_bus_arbiter #(.MAX_WAIT(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_m0_req    (m0_req),
        .i_m0_we     (m0_we),
        .i_m0_be     (m0_be),
        .i_m0_addr   (m0_addr),
        .i_m0_wdata  (m0_wdata),
        .i_m1_req    (m1_req),
        .i_m1_we     (m1_we),
        .i_m1_be     (m1_be),
        .i_m1_addr   (m1_addr),
        .i_m1_wdata  (m1_wdata),
        .o_m0_gnt    (m0_gnt),
        .o_m0_rvalid (m0_rvalid),
        .o_m0_err    (m0_err),
        .o_m0_rdata  (m0_rdata),
        .o_m1_gnt    (m1_gnt),
        .o_m1_rvalid (m1_rvalid),
        .o_m1_err    (m1_err),
        .o_m1_rdata  (m1_rdata),
        .o_s_addr    (s_addr),
        .o_s_wdata   (s_wdata),
        .o_s_be      (s_be),
        .o_dm_we     (dm_we),
        .o_tc0_we    (tc0_we),
        .o_tc1_we    (tc1_we),
        .o_ig_we     (ig_we),
        .i_dm_rdata  (dm_rdata),
        .i_tc0_rdata (tc0_rdata),
        .i_tc1_rdata (tc1_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a single m0 access (m1 idle).
    task automatic m0_drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
        m0_req = 1'b1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic idle();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h0; m1_wdata = 32'h0;
        dm_rdata = 32'h0; tc0_rdata = 32'h0; tc1_rdata = 32'h0;

        // Reset state, even with requests pending.
        @(negedge clk); @(negedge clk); #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_we", {28'h0, dm_we, tc0_we, tc1_we, ig_we}, 32'h0);
        idle();
        @(negedge clk);
        reset = 1'b0;

        // m0 DM read.
        @(negedge clk);
        m0_drive(1'b0, 4'hF, 32'h0000_1000, 32'h0); #1;
        chk("rd_dm_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        chk("rd_dm_saddr", s_addr, 32'h0000_1000);
        @(negedge clk);
        idle(); dm_rdata = 32'h1234_5678; #1;
        chk("rd_dm_rvalid", 32'(m0_rvalid), 32'h1);
        chk("rd_dm_err", 32'(m0_err), 32'h0);
        chk("rd_dm_rdata", m0_rdata, 32'h1234_5678);
        chk("rd_dm_m1_quiet", {m1_rdata[29:0], m1_err, m1_rvalid}, 32'h0);

        // m1 DM read routed to m1 only.
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h0000_2000; #1;
        chk("m1_rd_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h2);
        chk("m1_rd_saddr", s_addr, 32'h0000_2000);
        @(negedge clk);
        idle(); dm_rdata = 32'hCAFE_F00D; #1;
        chk("m1_rd_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
        chk("m1_rd_rdata", m1_rdata, 32'hCAFE_F00D);
        chk("m1_rd_m0_rdata", m0_rdata, 32'h0);

        // Timer write with partial byte enables: rejected.
        @(negedge clk);
        m0_drive(1'b1, 4'b0011, 32'h0000_7F04, 32'hDEAD_BEEF); #1;
        chk("tc0_part_we", 32'(tc0_we), 32'h0);
        @(negedge clk);
        idle(); #1;
        chk("tc0_part_resp", {29'h0, m0_rvalid, m0_err, 1'b0}, 32'h6);

        // Write to read-only COUNT: rejected.
        @(negedge clk);
        m0_drive(1'b1, 4'hF, 32'h0000_7F18, 32'hDEAD_BEEF); #1;
        chk("tc1_cnt_we", 32'(tc1_we), 32'h0);
        @(negedge clk);
        idle(); #1;
        chk("tc1_cnt_err", 32'(m0_err), 32'h1);

        // Legal timer write.
        @(negedge clk);
        m0_drive(1'b1, 4'hF, 32'h0000_7F14, 32'hDEAD_BEEF); #1;
        chk("tc1_ok_we", 32'(tc1_we), 32'h1);
        chk("tc1_ok_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("tc1_ok_other_we", {29'h0, dm_we, tc0_we, ig_we}, 32'h0);
        @(negedge clk);
        idle(); #1;
        chk("tc1_ok_resp", {m0_rdata[29:0], m0_rvalid, m0_err}, 32'h2);

        // Read of an unmapped DM hole: error, data masked.
        @(negedge clk);
        m0_drive(1'b0, 4'hF, 32'h0000_3000, 32'h0); #1;
        chk("miss_dm_we", {28'h0, dm_we, tc0_we, tc1_we, ig_we}, 32'h0);
        @(negedge clk);
        idle(); dm_rdata = 32'h1111_2222; #1;
        chk("miss_dm_err", 32'(m0_err), 32'h1);
        chk("miss_dm_rdata", m0_rdata, 32'h0);

        // Read just past TC0: error, timer data not returned.
        @(negedge clk);
        m0_drive(1'b0, 4'hF, 32'h0000_7F0C, 32'h0); tc0_rdata = 32'h99; #1;
        chk("miss_tc0_gnt", 32'(m0_gnt), 32'h1);
        @(negedge clk);
        idle(); #1;
        chk("miss_tc0_err", 32'(m0_err), 32'h1);
        chk("miss_tc0_rdata", m0_rdata, 32'h0);

        // Zero byte enables on DM: error, no strobe.
        @(negedge clk);
        m0_drive(1'b1, 4'h0, 32'h0000_0000, 32'h5); #1;
        chk("be0_dm_we", 32'(dm_we), 32'h0);
        @(negedge clk);
        idle(); #1;
        chk("be0_err", 32'(m0_err), 32'h1);

        // IG write.
        @(negedge clk);
        m0_drive(1'b1, 4'hF, 32'h0000_7F20, 32'h1); #1;
        chk("ig_we", 32'(ig_we), 32'h1);
        @(negedge clk);
        idle(); #1;
        chk("ig_resp", {30'h0, m0_rvalid, m0_err}, 32'h2);

        // Continuous contention: m0 x4, m1, m0 x4, m1, m0 x2.
        @(negedge clk);
        m0_drive(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h0000_0020;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("arb_gnt_%0d", i), {30'h0, m1_gnt, m0_gnt},
                exp_m1[i] ? 32'h2 : 32'h1);
            chk($sformatf("arb_saddr_%0d", i), s_addr,
                exp_m1[i] ? 32'h0000_0020 : 32'h0000_0010);
            if (i > 0) begin
                chk($sformatf("arb_rvalid_%0d", i), {30'h0, m1_rvalid, m0_rvalid},
                    exp_m1[i-1] ? 32'h2 : 32'h1);
            end
        end
        @(negedge clk);
        idle(); #1;
        chk("arb_last_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);

        // Back-to-back: TC0 COUNT read then DM read.
        @(negedge clk);
        m0_drive(1'b0, 4'hF, 32'h0000_7F08, 32'h0); tc0_rdata = 32'h55; #1;
        chk("b2b_gnt0", 32'(m0_gnt), 32'h1);
        @(negedge clk);
        m0_addr = 32'h0000_0004; tc0_rdata = 32'h77; dm_rdata = 32'h0BAD; #1;
        chk("b2b_gnt1", 32'(m0_gnt), 32'h1);
        chk("b2b_rvalid0", 32'(m0_rvalid), 32'h1);
        chk("b2b_rdata0", m0_rdata, 32'h55);
        @(negedge clk);
        idle(); dm_rdata = 32'hAA; #1;
        chk("b2b_rvalid1", 32'(m0_rvalid), 32'h1);
        chk("b2b_rdata1", m0_rdata, 32'hAA);

        // Reset one cycle after a grant discards the response.
        @(negedge clk);
        m0_drive(1'b0, 4'hF, 32'h0000_0000, 32'h0);
        m1_req = 1'b1; m1_addr = 32'h0000_0008; #1;
        chk("rstd_gnt", 32'(m0_gnt), 32'h1);
        @(negedge clk);
        reset = 1'b1; #1;
        chk("rstd_rvalid1", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk("rstd_gnt1", {30'h0, m1_gnt, m0_gnt}, 32'h0);
        chk("rstd_rdata1", m0_rdata | m1_rdata, 32'h0);
        chk("rstd_s_bus", s_addr | s_wdata | {28'h0, s_be}, 32'h0);
        @(negedge clk);
        reset = 1'b0; idle(); #1;
        chk("rstd_rvalid2", {28'h0, m1_err, m0_err, m1_rvalid, m0_rvalid}, 32'h0);
        chk("rstd_wait_cnt", 32'(dut.r_wait_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
